// File: rtl/aes_round_transforms_pkg.sv
// Shared AES constants: S-box tables, GF(2^8) helpers and datapath widths.
package aes_pkg;

    localparam int BYTE_W  = 8;
    localparam int COL_W   = 32;
    localparam int STATE_W = 128;

    typedef logic [BYTE_W-1:0] aes_byte_t;

    localparam aes_byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t mul02(input aes_byte_t b);
        return xtime(b);
    endfunction

    function automatic aes_byte_t mul03(input aes_byte_t b);
        return xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t mul09(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic aes_byte_t mul0b(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t mul0d(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic aes_byte_t mul0e(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_round_transforms_if.sv
// Request/result bundle between the round controller and the transform datapath.
interface aes_round_transforms_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               inv_en;
    logic [BYTE_W-1:0]  byte_in;
    logic [STATE_W-1:0] shift_rows_in;
    logic [COL_W-1:0]   mix_col_in;
    logic               out_valid;
    logic [BYTE_W-1:0]  byte_o;
    logic [STATE_W-1:0] shift_rows_o;
    logic [COL_W-1:0]   mix_col_o;

    modport master (
        output in_valid, inv_en, byte_in, shift_rows_in, mix_col_in,
        input  out_valid, byte_o, shift_rows_o, mix_col_o
    );

    modport slave (
        input  in_valid, inv_en, byte_in, shift_rows_in, mix_col_in,
        output out_valid, byte_o, shift_rows_o, mix_col_o
    );
endinterface

// File: rtl/aes_round_transforms_sbox.sv
// Combinational forward/inverse AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic      inv_en,
    input  aes_byte_t value,
    output aes_byte_t result
);
    always_comb begin
        result = inv_en ? SBOX_INV[value] : SBOX_FWD[value];
    end
endmodule

// File: rtl/aes_round_transforms.sv
// AES round transforms (SubBytes, ShiftRows, MixColumns and inverses) behind one output register.
module aes_round_transforms
    import aes_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    aes_round_transforms_if.slave bus
);
    aes_byte_t          sub_next;
    logic [STATE_W-1:0] shift_next;
    logic [COL_W-1:0]   mix_next;
    aes_byte_t          a0, a1, a2, a3;

    aes_sbox u_sbox (
        .inv_en (bus.inv_en),
        .value  (bus.byte_in),
        .result (sub_next)
    );

    // Byte r+4c of the output takes row r from column (c+r) mod 4 (forward) or (c-r) mod 4 (inverse).
    always_comb begin
        shift_next = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                shift_next[STATE_W-1-8*(r+4*c) -: 8] =
                    bus.shift_rows_in[STATE_W-1-8*(r+4*(bus.inv_en ? ((c+4-r) % 4) : ((c+r) % 4))) -: 8];
            end
        end
    end

    always_comb begin
        a0 = bus.mix_col_in[31:24];
        a1 = bus.mix_col_in[23:16];
        a2 = bus.mix_col_in[15:8];
        a3 = bus.mix_col_in[7:0];
        if (bus.inv_en) begin
            mix_next = {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                        mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                        mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                        mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
        end else begin
            mix_next = {mul02(a0) ^ mul03(a1) ^ a2        ^ a3,
                        a0        ^ mul02(a1) ^ mul03(a2) ^ a3,
                        a0        ^ a1        ^ mul02(a2) ^ mul03(a3),
                        mul03(a0) ^ a1        ^ a2        ^ mul02(a3)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.byte_o       <= '0;
            bus.shift_rows_o <= '0;
            bus.mix_col_o    <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.byte_o       <= sub_next;
                bus.shift_rows_o <= shift_next;
                bus.mix_col_o    <= mix_next;
            end
        end
    end
endmodule

// File: tb/tb_aes_round_transforms.sv
// Randomized and directed checks of aes_round_transforms against a GF(2^8) reference model.
module tb_aes_round_transforms;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aes_round_transforms_if bus ();

    aes_round_transforms dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  m_fwd [256];
    logic [7:0]  m_inv [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int x = 1; x < 256; x++)
            if (gf_mul(a, 8'(x)) == 8'h01) return 8'(x);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_model(input logic inv, input logic [127:0] s);
        logic [7:0]   st [4][4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) st[i % 4][i / 4] = s[127-8*i -: 8];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = inv ? st[r][(c + 4 - r) % 4] : st[r][(c + r) % 4];
        return o;
    endfunction

    function automatic logic [31:0] mix_model(input logic inv, input logic [31:0] m);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] b;
        logic [31:0] o;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int j = 0; j < 4; j++) a[j] = m[31-8*j -: 8];
        o = '0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gf_mul(coef[(j - i + 4) % 4], a[j]);
            o[31-8*i -: 8] = b;
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic txn(input logic inv, input logic [7:0] b, input logic [127:0] s, input logic [31:0] m,
                       output logic [7:0] bo, output logic [127:0] so, output logic [31:0] mo);
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.inv_en        = inv;
        bus.byte_in       = b;
        bus.shift_rows_in = s;
        bus.mix_col_in    = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bo = bus.byte_o;
        so = bus.shift_rows_o;
        mo = bus.mix_col_o;
        check("out_valid", 128'(bus.out_valid), 128'(1'b1));
        check("byte_o", 128'(bo), 128'(inv ? m_inv[b] : m_fwd[b]));
        check("shift_rows_o", so, shift_model(inv, s));
        check("mix_col_o", 128'(mo), 128'(mix_model(inv, m)));
    endtask

    logic [7:0]   bo, y, z;
    logic [127:0] so, sb, res;
    logic [31:0]  mo;
    logic [127:0] st0;
    logic [7:0]   hb;
    logic [127:0] hs;
    logic [31:0]  hm;

    initial begin
        bus.in_valid      = 1'b0;
        bus.inv_en        = 1'b0;
        bus.byte_in       = '0;
        bus.shift_rows_in = '0;
        bus.mix_col_in    = '0;

        for (int x = 0; x < 256; x++) m_fwd[x] = affine(gf_inv(8'(x)));
        for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);

        #12;
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset byte_o", 128'(bus.byte_o), 128'(0));
        check("reset shift_rows_o", bus.shift_rows_o, 128'(0));
        check("reset mix_col_o", 128'(bus.mix_col_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed known-answer vectors.
        txn(1'b0, 8'h00, 128'h000102030405060708090a0b0c0d0e0f, 32'hdb135345, bo, so, mo);
        check("kat sbox 00", 128'(bo), 128'(8'h63));
        check("kat shift fwd", so, 128'h00050a0f04090e03080d02070c01060b);
        check("kat mix db135345", 128'(mo), 128'(32'h8e4da1bc));
        txn(1'b0, 8'h53, rand128(), 32'hf20a225c, bo, so, mo);
        check("kat sbox 53", 128'(bo), 128'(8'hed));
        check("kat mix f20a225c", 128'(mo), 128'(32'h9fdc589d));
        txn(1'b0, 8'hff, rand128(), 32'h01010101, bo, so, mo);
        check("kat sbox ff", 128'(bo), 128'(8'h16));
        check("kat mix 01010101", 128'(mo), 128'(32'h01010101));
        txn(1'b1, 8'h63, 128'h00050a0f04090e03080d02070c01060b, 32'h8e4da1bc, bo, so, mo);
        check("kat isbox 63", 128'(bo), 128'(8'h00));
        check("kat shift inv", so, 128'h000102030405060708090a0b0c0d0e0f);
        check("kat imix 8e4da1bc", 128'(mo), 128'(32'hdb135345));
        txn(1'b1, 8'hed, rand128(), $urandom, bo, so, mo);
        check("kat isbox ed", 128'(bo), 128'(8'h53));

        // AES-256 round 1 state path from FIPS-197 C.3.
        st0 = 128'h00102030405060708090a0b0c0d0e0f0;
        sb  = '0;
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, st0[127-8*i -: 8], rand128(), $urandom, bo, so, mo);
            sb[127-8*i -: 8] = bo;
        end
        check("round sub_bytes", sb, 128'h63cab7040953d051cd60e0e7ba70e18c);
        txn(1'b0, $urandom, sb, $urandom, bo, so, mo);
        check("round shift_rows", so, 128'h6353e08c0960e104cd70b751bacad0e7);
        sb  = so;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            txn(1'b0, $urandom, rand128(), sb[127-32*c -: 32], bo, so, mo);
            res[127-32*c -: 32] = mo;
        end
        check("round mix_columns", res, 128'h5f72641557f5bc92f7be3b291db9f91a);

        // Inverse S-box undoes forward S-box for every byte value.
        for (int x = 0; x < 256; x++) begin
            txn(1'b0, 8'(x), rand128(), $urandom, y, so, mo);
            txn(1'b1, y, rand128(), $urandom, z, so, mo);
            check("sbox roundtrip", 128'(z), 128'(x));
        end

        // Random mixed-mode traffic.
        for (int i = 0; i < 150; i++)
            txn(1'($urandom), 8'($urandom), rand128(), $urandom, bo, so, mo);

        // Single valid pulse, then outputs must hold while inputs wander.
        txn(1'b1, 8'($urandom), rand128(), $urandom, hb, hs, hm);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid      = 1'b0;
            bus.inv_en        = 1'($urandom);
            bus.byte_in       = 8'($urandom);
            bus.shift_rows_in = rand128();
            bus.mix_col_in    = $urandom;
            @(posedge clk);
            #1;
            check("hold out_valid", 128'(bus.out_valid), 128'(0));
            check("hold byte_o", 128'(bus.byte_o), 128'(hb));
            check("hold shift_rows_o", bus.shift_rows_o, hs);
            check("hold mix_col_o", 128'(bus.mix_col_o), 128'(hm));
        end

        // Asynchronous reset mid-stream, between clock edges.
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.inv_en        = 1'b0;
        bus.byte_in       = 8'h00;
        bus.shift_rows_in = 128'h000102030405060708090a0b0c0d0e0f;
        bus.mix_col_in    = 32'h01010101;
        @(posedge clk);
        #3;
        check("pre-reset byte_o", 128'(bus.byte_o), 128'(8'h63));
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 128'(bus.out_valid), 128'(0));
        check("async reset byte_o", 128'(bus.byte_o), 128'(0));
        check("async reset shift_rows_o", bus.shift_rows_o, 128'(0));
        check("async reset mix_col_o", 128'(bus.mix_col_o), 128'(0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset idle out_valid", 128'(bus.out_valid), 128'(0));
        check("post-reset idle mix_col_o", 128'(bus.mix_col_o), 128'(0));
        txn(1'b0, 8'h53, rand128(), 32'hdb135345, bo, so, mo);
        check("resume sbox 53", 128'(bo), 128'(8'hed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
